interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter VEC_BASE, default 32'h0000_0100, base ISR address.
REQ-002 SHALL have parameter VEC_SHIFT, default 4, log2 of the byte spacing between vectors.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port irq  input  4  external interrupt request lines, asynchronous, rising-edge significant.
REQ-006 SHALL have port mask_wr  input  1  write strobe for the mask register.
REQ-007 SHALL have port mask_din  input  4  new mask value; bit=1 disables that line.
REQ-008 SHALL have port ack  input  1  core acknowledges the interrupt and takes the vector, single-cycle pulse.
REQ-009 SHALL have port eoi  input  1  core signals end of the service routine, single-cycle pulse.
REQ-010 SHALL have port INT  output  1  interrupt request to the core's INT input.
REQ-011 SHALL have port vector  output  32  ISR address for the selected line.
REQ-012 SHALL have port active_id  output  2  line currently selected or in service.
REQ-013 SHALL have port pending  output  4  latched, not-yet-acknowledged requests.
REQ-014 SHALL have port in_service  output  1  high while a routine is executing (between ack and eoi).

Function
REQ-015 SHALL set pending[i] on the clock edge where the (synchronised) irq[i] is 1 and its previous sampled value was 0; level-high without an edge SHALL NOT re-set pending.
REQ-016 Eligible set SHALL be pending & ~mask; the selected line SHALL be the lowest eligible index (line 0 highest priority).
REQ-017 SHALL implement FSM states IDLE, ASSERT, SERVICE; INT SHALL be registered and high exactly in ASSERT.
REQ-018 IDLE->ASSERT SHALL occur on the edge where the eligible set is non-zero; active_id SHALL latch the selected line on that edge; INT SHALL be high from the following cycle.
REQ-019 In ASSERT, active_id and vector SHALL be frozen; a higher-priority arrival SHALL only become pending (no preemption).
REQ-020 In ASSERT, if mask_wr masks active_id and ack is low, the FSM SHALL return to IDLE with INT low next cycle; ack SHALL be evaluated against the pre-write mask.
REQ-021 ASSERT+ack SHALL clear pending[active_id], enter SERVICE, drop INT and raise in_service on the next cycle.
REQ-022 A new edge on line active_id in the ack cycle SHALL leave pending[active_id] set (set wins over clear).
REQ-023 In SERVICE, requests SHALL accumulate in pending; INT SHALL stay low (no nesting).
REQ-024 SERVICE+eoi SHALL return to IDLE; if the eligible set is non-zero, INT SHALL reassert one cycle after re-entering IDLE.
REQ-025 ack outside ASSERT and eoi outside SERVICE SHALL be ignored.
REQ-026 vector SHALL equal VEC_BASE + (active_id << VEC_SHIFT), 32-bit, with wrap-around on overflow.
REQ-027 mask_wr SHALL update the mask on the clock edge; it SHALL NOT alter pending.

Reset
REQ-028 On rst low, SHALL asynchronously force: state IDLE, INT 0, in_service 0, active_id 0, vector VEC_BASE, pending 0, mask 4'b1111, synchroniser and edge flops 0.
REQ-029 Reset mid-ASSERT or mid-SERVICE SHALL discard all pending and active state; no INT until a fresh edge occurs after release.
REQ-030 An irq held high through reset release SHALL count as an edge at its first sample after release.

Configuration
REQ-031 With INTC_SYNC_EN defined, each irq line SHALL pass through a two-flop synchroniser; pending is visible two cycles after the sampling edge, and INT is high three cycles after the first sampling edge.
REQ-032 Without INTC_SYNC_EN, irq SHALL be sampled directly; pending is visible after the sampling edge and INT is high one cycle later; all other behaviour is identical.

Verification
REQ-033 Reset, write mask=0, pulse irq[2] -> pending=4'b0100, INT high at the REQ-031/032 latency, vector=32'h0000_0120, active_id=2.
REQ-034 irq[3] and irq[1] rise in the same cycle -> active_id=1, vector=32'h0000_0110; after ack+eoi INT reasserts with active_id=3, vector=32'h0000_0130.
REQ-035 In SERVICE with line 0, irq[0] edge -> pending[0]=1, INT stays low; eoi -> INT high next-but-one cycle, active_id=0.
REQ-036 In ASSERT on line 2, mask_wr with mask_din=4'b0100 and no ack -> INT low next cycle, pending[2] stays 1; unmasking -> INT reasserts.
REQ-037 Edge on irq[1] in the same cycle as ack of line 1 -> pending[1]=1 after ack; a stray eoi in IDLE and a stray ack in SERVICE produce no change.
REQ-038 rst low during SERVICE -> outputs per REQ-028 immediately; with irq held high through release, an edge is detected per REQ-030.

Source files
------------

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - four-line edge-triggered interrupt controller with priority, mask and ack/eoi handshake
// Optional build macro INTC_SYNC_EN adds a two-flop synchroniser on every irq line.
module interrupt_controller #(
    parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
    parameter int          VEC_SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  irq,
    input  logic        mask_wr,
    input  logic [3:0]  mask_din,
    input  logic        ack,
    input  logic        eoi,
    output logic        INT,
    output logic [31:0] vector,
    output logic [1:0]  active_id,
    output logic [3:0]  pending,
    output logic        in_service
);

    typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

    state_t     state, state_n;
    logic [3:0] irq_s;
    logic [3:0] irq_prev;
    logic [3:0] rise;
    logic [3:0] mask;
    logic [3:0] eligible;
    logic [3:0] clr;
    logic [1:0] sel;
    logic       latch_id;

`ifdef INTC_SYNC_EN
    logic [3:0] sync1, sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 4'b0000;
            sync2 <= 4'b0000;
        end else begin
            sync1 <= irq;
            sync2 <= sync1;
        end
    end

    assign irq_s = sync2;
`else
    assign irq_s = irq;
`endif

    // previous sample resets to 0 so a line held high through reset release counts as an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) irq_prev <= 4'b0000;
        else      irq_prev <= irq_s;
    end

    assign rise     = irq_s & ~irq_prev;
    assign eligible = pending & ~mask;

    always_comb begin
        sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (eligible[i]) sel = 2'(i);
        end
    end

    // ack is checked before the mask write so an acknowledge always wins over a same-cycle mask
    always_comb begin
        state_n  = state;
        clr      = 4'b0000;
        latch_id = 1'b0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_n  = ASSERT;
                    latch_id = 1'b1;
                end
            end
            ASSERT: begin
                if (ack) begin
                    state_n        = SERVICE;
                    clr[active_id] = 1'b1;
                end else if (mask_wr && mask_din[active_id]) begin
                    state_n = IDLE;
                end
            end
            SERVICE: begin
                if (eoi) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            active_id <= 2'd0;
            pending   <= 4'b0000;
            mask      <= 4'b1111;
        end else begin
            state <= state_n;
            if (latch_id) active_id <= sel;
            pending <= (pending & ~clr) | rise;
            if (mask_wr) mask <= mask_din;
        end
    end

    assign INT        = (state == ASSERT);
    assign in_service = (state == SERVICE);
    assign vector     = VEC_BASE + ({30'd0, active_id} << VEC_SHIFT);

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - directed and randomized checks of interrupt_controller against a behavioural model
module tb_interrupt_controller;

    localparam logic [31:0] VB = 32'h0000_0100;
    localparam int          VS = 4;
`ifdef INTC_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  irq = 4'b0000;
    logic        mask_wr = 1'b0;
    logic [3:0]  mask_din = 4'b0000;
    logic        ack = 1'b0;
    logic        eoi = 1'b0;
    logic        int_line;
    logic [31:0] vector;
    logic [1:0]  active_id;
    logic [3:0]  pending;
    logic        in_service;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural view: a request is waiting for ack, or a routine is running, or neither
    bit       m_wait, m_serv;
    int       m_id;
    bit [3:0] m_pend, m_mask, m_prev, m_s1, m_s2;

    interrupt_controller #(.VEC_BASE(VB), .VEC_SHIFT(VS)) dut (
        .clk(clk), .rst(rst), .irq(irq), .mask_wr(mask_wr), .mask_din(mask_din),
        .ack(ack), .eoi(eoi), .INT(int_line), .vector(vector),
        .active_id(active_id), .pending(pending), .in_service(in_service)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset;
        m_wait = 0; m_serv = 0; m_id = 0;
        m_pend = 4'b0000; m_mask = 4'b1111;
        m_prev = 4'b0000; m_s1 = 4'b0000; m_s2 = 4'b0000;
    endtask

    task automatic model_step;
        bit [3:0] samp, rises, elig, clr;
`ifdef INTC_SYNC_EN
        samp = m_s2;
`else
        samp = irq;
`endif
        rises = samp & ~m_prev;
        elig  = m_pend & ~m_mask;
        clr   = 4'b0000;
        if (m_wait) begin
            if (ack) begin
                clr[m_id] = 1'b1;
                m_wait = 0;
                m_serv = 1;
            end else if (mask_wr && mask_din[m_id]) begin
                m_wait = 0;
            end
        end else if (m_serv) begin
            if (eoi) m_serv = 0;
        end else if (elig != 0) begin
            for (int i = 3; i >= 0; i--) if (elig[i]) m_id = i;
            m_wait = 1;
        end
        m_pend = (m_pend & ~clr) | rises;
        if (mask_wr) m_mask = mask_din;
        m_s2   = m_s1;
        m_s1   = irq;
        m_prev = samp;
    endtask

    task automatic compare_all;
        check("int", {31'd0, int_line}, {31'd0, m_wait});
        check("in_service", {31'd0, in_service}, {31'd0, m_serv});
        check("active_id", {30'd0, active_id}, 32'(m_id));
        check("vector", vector, VB + 32'(m_id) * (32'd1 << VS));
        check("pending", {28'd0, pending}, {28'd0, m_pend});
    endtask

    task automatic tick;
        @(posedge clk);
        if (rst) model_step();
        else     model_reset();
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic set_mask(input logic [3:0] m);
        mask_wr = 1'b1; mask_din = m;
        tick();
        mask_wr = 1'b0;
    endtask

    task automatic pulse_ack;
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic pulse_eoi;
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    // asserts reset between clock edges and checks the outputs before the next edge
    task automatic do_reset;
        #2 rst = 1'b0;
        #1 model_reset();
        check("rst_int", {31'd0, int_line}, 32'd0);
        check("rst_in_service", {31'd0, in_service}, 32'd0);
        check("rst_active_id", {30'd0, active_id}, 32'd0);
        check("rst_vector", vector, VB);
        check("rst_pending", {28'd0, pending}, 32'd0);
        tick();
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b1;

        // single line 2
        set_mask(4'b0000);
        irq = 4'b0100;
        ticks(1 + SL);
        check("r33_pending", {28'd0, pending}, 32'h4);
        check("r33_int_early", {31'd0, int_line}, 32'd0);
        tick();
        check("r33_int", {31'd0, int_line}, 32'd1);
        check("r33_vector", vector, 32'h0000_0120);
        check("r33_id", {30'd0, active_id}, 32'd2);
        pulse_ack();
        pulse_eoi();
        irq = 4'b0000;
        ticks(4);

        // simultaneous lines 3 and 1
        irq = 4'b1010;
        ticks(1 + SL);
        tick();
        check("r34_id1", {30'd0, active_id}, 32'd1);
        check("r34_vec1", vector, 32'h0000_0110);
        pulse_ack();
        pulse_eoi();
        tick();
        check("r34_int3", {31'd0, int_line}, 32'd1);
        check("r34_id3", {30'd0, active_id}, 32'd3);
        check("r34_vec3", vector, 32'h0000_0130);
        pulse_ack();
        pulse_eoi();
        irq = 4'b0000;
        ticks(4);

        // new edge on line 0 while servicing line 0
        irq = 4'b0001;
        ticks(1 + SL);
        tick();
        pulse_ack();
        irq = 4'b0000;
        ticks(4);
        irq = 4'b0001;
        ticks(1 + SL);
        check("r35_pend0", {31'd0, pending[0]}, 32'd1);
        check("r35_no_nest", {31'd0, int_line}, 32'd0);
        pulse_eoi();
        check("r35_int_idle", {31'd0, int_line}, 32'd0);
        tick();
        check("r35_int", {31'd0, int_line}, 32'd1);
        check("r35_id", {30'd0, active_id}, 32'd0);
        pulse_ack();
        pulse_eoi();
        irq = 4'b0000;
        ticks(4);

        // masking the asserted line withdraws INT
        irq = 4'b0100;
        ticks(1 + SL);
        tick();
        set_mask(4'b0100);
        check("r36_int_off", {31'd0, int_line}, 32'd0);
        check("r36_pend2", {31'd0, pending[2]}, 32'd1);
        tick();
        set_mask(4'b0000);
        tick();
        check("r36_int_back", {31'd0, int_line}, 32'd1);
        pulse_ack();
        pulse_eoi();
        irq = 4'b0000;
        ticks(4);

        // stray eoi, edge coincident with ack, stray ack
        pulse_eoi();
        check("r37_stray_eoi", {28'd0, int_line, in_service, 2'b00}, 32'd0);
        irq = 4'b0010;
        ticks(1 + SL);
        irq = 4'b0000;
        ticks(4);
        irq = 4'b0010;
        ticks(SL);
        pulse_ack();
        check("r37_pend1", {31'd0, pending[1]}, 32'd1);
        check("r37_svc", {31'd0, in_service}, 32'd1);
        pulse_ack();
        check("r37_stray_ack", {30'd0, in_service, int_line}, 32'd2);
        pulse_eoi();
        tick();
        check("r37_reassert", {29'd0, int_line, active_id}, 32'd5);
        pulse_ack();
        pulse_eoi();
        irq = 4'b0000;
        ticks(4);

        // reset in SERVICE with irq held high through release
        irq = 4'b1000;
        ticks(1 + SL);
        tick();
        pulse_ack();
        do_reset();
        ticks(1 + SL);
        check("r38_pend3", {28'd0, pending}, 32'h8);
        check("r38_masked", {31'd0, int_line}, 32'd0);
        set_mask(4'b0000);
        tick();
        check("r38_int", {29'd0, int_line, active_id}, 32'd7);
        pulse_ack();
        pulse_eoi();
        irq = 4'b0000;
        ticks(4);

        // randomized traffic
        set_mask(4'b0000);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) irq = irq ^ 4'(1 << $urandom_range(0, 3));
            ack     = ($urandom_range(0, 3) == 0);
            eoi     = ($urandom_range(0, 3) == 0);
            mask_wr = ($urandom_range(0, 15) == 0);
            mask_din = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            if ($urandom_range(0, 499) == 0) begin
                ack = 1'b0; eoi = 1'b0; mask_wr = 1'b0;
                do_reset();
            end else begin
                tick();
            end
        end
        ack = 1'b0; eoi = 1'b0; mask_wr = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
